fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch front end for the pipelined core. It owns the fetch PC, issues word reads to the synchronous instruction RAM, and buffers returned instructions in a DEPTH-entry FIFO ahead of the decode stage. Decode therefore sees a valid/ready stream instead of a single stage register. A redirect from the memory-access stage (branch, jump, jr, jal) flushes the queue and all in-flight reads and restarts fetch at the new target.

## Interface
Parameters:
- XLEN, 32, width of PC and addresses.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  read request this cycle.
- mem_addr  output  XLEN  byte address of the request; bits [1:0] always 0.
- mem_rdata  input  32  read data; valid the cycle after a request (fixed 1-cycle latency; RAM never stalls).
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  XLEN  restart target; bits [1:0] ignored (treated as 00).
- out_valid  output  1  head entry present.
- deq_ready  input  1  decode accepts head; deq_fire = out_valid & deq_ready.
- out_ins  output  32  head instruction.
- out_pc  output  XLEN  address of head instruction.
- out_next_pc  output  XLEN  out_pc + 4, modulo 2^XLEN.
- count  output  clog2(DEPTH+1)  entries currently held.

## Operation
State:
- fetch_pc: next address to request.
- pend: 1 while a response is due next cycle.
- Circular buffer with head and tail pointers (log2(DEPTH) bits, wrap naturally) and a count.

Behaviour:
- Issue rule: mem_req = !reset & !redirect_valid & (count + pend - deq_fire < DEPTH). The arithmetic is evaluated wide enough to avoid underflow.
- Issue: mem_addr = fetch_pc. On issue, fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN) and pend <= 1; otherwise pend <= 0.
- Response: in the cycle after an issue (pend = 1, no redirect), {mem_rdata, pc of that request} is written at tail and tail advances.
- Dequeue: deq_fire advances head.
- Count: count += enqueue - deq_fire. Simultaneous enqueue and dequeue leaves count unchanged, including when count = DEPTH-1 or count = 1.
- Full: count = DEPTH with no deq_fire gives mem_req = 0. The issue rule guarantees an arriving response always has a free slot, so no overflow is possible.
- Empty: out_valid = 0. out_ins and out_pc are don't-care.
- Redirect (priority over everything except reset):
  - count, head and tail <= 0.
  - A response arriving that cycle, or a pending one, is discarded.
  - pend <= 0 and fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - A deq_fire in the redirect cycle is permitted but has no effect on state.
- Back-to-back redirects: the last one wins. Fetch resumes the cycle after the final redirect.
- Reset: same as a redirect to RESET_PC. Reset may assert at any time, including with the queue full and a read pending. The storage array need not be reset.

## Timing
Reset values:
- mem_req = 0, out_valid = 0, count = 0, fetch_pc = RESET_PC, pend = 0.

Latencies:
- Issue to visible: request in cycle R, data sampled in R+1, out_valid in R+2.
- First cycle with reset low = C: request to RESET_PC in C; out_valid with out_pc = RESET_PC in C+2.
- Redirect asserted in cycle N: out_valid = 0 in N+1; request to target in N+1; target at head in N+3.

Throughput:
- One instruction per cycle sustained with deq_ready held high, for any DEPTH >= 2.

## Test plan
- Straight line: RESET_PC = 0, RAM holds ins = 0xA000_0000 | addr, deq_ready = 1 → out_valid from C+2; out_pc 0,4,8,… on consecutive cycles; out_ins matches; out_next_pc = out_pc + 4.
- Backpressure: DEPTH = 4, deq_ready = 0 → exactly 4 requests (addresses 0x0–0xC); count = 4; mem_req stays 0. A single deq_fire → one request to 0x10 in the same cycle; count returns to 4 two cycles later.
- Redirect in flight: redirect_pc = 0x100 in the cycle a response for 0x8 arrives → 0x8 is never presented; count = 0 in N+1; request to 0x100 in N+1; out_pc = 0x100 in N+3; then 0x104.
- Misaligned redirect: redirect_pc = 0x203 → mem_addr = 0x200 and out_pc = 0x200.
- Wrap-around: RESET_PC = 0xFFFF_FFF8 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000. For FFFF_FFFC, out_next_pc = 0.
- Mid-operation reset: queue full with a read pending, reset held 2 cycles → during reset mem_req = 0, out_valid = 0, count = 0; after release, first request to RESET_PC and no stale entry is ever output.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency RAM reads
// and buffers returned instructions in a DEPTH-entry FIFO ahead of decode.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       mem_req,
    output logic [XLEN-1:0]            mem_addr,
    input  logic [31:0]                mem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       deq_ready,
    output logic [31:0]                out_ins,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_next_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] pend_pc_reg;
    logic            pend_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;

    logic [31:0]     ins_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];

    logic          flush;
    logic          enq;
    logic          deq_fire;
    logic          issue;
    logic [CW:0]   occupancy;
    logic          unused_ok;

    assign unused_ok = &{1'b0, redirect_pc[1:0]};

    assign flush     = reset | redirect_valid;
    assign out_valid = (count_reg != '0);
    assign deq_fire  = out_valid & deq_ready;
    assign enq       = pend_reg & ~flush;

    // Held entries plus the response in flight must leave room for the new request;
    // comparing against DEPTH + deq_fire avoids the subtraction underflowing.
    assign occupancy = {1'b0, count_reg} + (CW+1)'(pend_reg);
    assign issue     = ~flush && (occupancy < ((CW+1)'(DEPTH) + (CW+1)'(deq_fire)));

    assign mem_req     = issue;
    assign mem_addr    = fetch_pc_reg;
    assign out_ins     = ins_mem[head_reg];
    assign out_pc      = pc_mem[head_reg];
    assign out_next_pc = out_pc + XLEN'(4);
    assign count       = count_reg;

    always_ff @(posedge clk) begin
        if (flush) begin
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            pend_reg     <= 1'b0;
            fetch_pc_reg <= reset ? RESET_PC : {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            pend_reg <= issue;
            if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                pend_pc_reg  <= fetch_pc_reg;
            end
            if (enq)
                tail_reg <= tail_reg + PW'(1);
            if (deq_fire)
                head_reg <= head_reg + PW'(1);
            count_reg <= count_reg + CW'(enq) - CW'(deq_fire);
        end
    end

    // Storage is deliberately left out of reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            ins_mem[tail_reg] <= mem_rdata;
            pc_mem[tail_reg]  <= pend_pc_reg;
        end
    end

endmodule
